btn_debounce_bank: RTL
======================

Name: btn_debounce_bank

Overview:
- Parametrised successor to the single-purpose button handling inside the VGA driver: N independent mechanical buttons (btnR/btnL/btnM/btnT today, more later).
- Per channel: synchronises, debounces, derives press/release/auto-repeat pulses.
- Merges all events into one valid/ready event stream consumed by the game/driver control logic.
- Sits between the board button pins and the driver FSM.

Parameters:
- N_BTN, 4, number of button channels (1..16).
- STABLE_CYCLES, 500000, consecutive synchronised cycles a new level must persist before acceptance (>=2).
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- REPEAT_EN, 1, 1 enables auto-repeat events; 0 suppresses them.
- REPEAT_DELAY, 50000000, cycles from the accepted press to the first repeat (>=2).
- REPEAT_RATE, 10000000, cycles between subsequent repeats (>=2).
- CH_W, 2, width of the channel index field, >= clog2(N_BTN).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; synchronous and active-high.
- btn_in, input, N_BTN, raw asynchronous button pins; bit i is channel i.
- btn_level, output, N_BTN, debounced level.
- btn_press, output, N_BTN, one-cycle pulse on accepted 0->1.
- btn_release, output, N_BTN, one-cycle pulse on accepted 1->0.
- btn_repeat, output, N_BTN, one-cycle auto-repeat pulse.
- event_valid, output, 1, event stream has a pending event.
- event_ch, output, CH_W, channel index of the offered event.
- event_type, output, 2, event kind: 01 press, 10 release, 11 repeat.
- event_ready, input, 1, consumer accepts the event.
- event_overrun, output, 1, one-cycle pulse when an event is coalesced into an already-pending one.

Behaviour:
Reset:
- rst sampled high on a clk edge clears the synchronisers, counters, btn_level, all pulse outputs, all pending bits and event_overrun.
- Reset applied mid-count or mid-handshake discards all state; no event survives reset.
- Outputs are 0 in the cycle after the reset edge.

Synchroniser and debounce (per channel):
- btn_in passes through a SYNC_STAGES flop chain; s_i is the last stage.
- Stable counter: cleared whenever s_i == btn_level[i]; otherwise incremented.
- When the counter equals STABLE_CYCLES-1 and s_i still differs from btn_level[i]: btn_level[i] toggles on the next edge and the counter clears.
- Any glitch shorter than STABLE_CYCLES synchronised cycles produces no level change.
- Latency: a clean step held from edge k makes btn_level change at edge k+SYNC_STAGES+STABLE_CYCLES.

Pulses:
- btn_press[i] is high in exactly the first cycle btn_level[i]=1; btn_release[i] likewise for the first cycle at 0.
- All pulse outputs are registered.

Repeat FSM (per channel, states IDLE / DELAY / RATE):
- IDLE: on press -> DELAY, repeat counter cleared.
- DELAY: counter reaches REPEAT_DELAY-1 -> btn_repeat pulse, -> RATE, counter cleared.
- RATE: counter reaches REPEAT_RATE-1 -> pulse, counter cleared, stay in RATE.
- Release in any state -> IDLE same edge; a release and a repeat terminal count in the same cycle yields the release only.
- REPEAT_EN=0: the FSM stays in IDLE and btn_repeat is constant 0.

Event stream:
- Three pending bits per channel (press/release/repeat), each set by the matching pulse.
- Offered event: lowest channel index with any pending bit; within a channel press > release > repeat.
- event_valid = OR of all pending bits; event_ch and event_type are derived from registered pending state only, with no combinational path from event_ready.
- event_valid && event_ready clears exactly the offered bit on that edge.
- Set and clear of the same bit in the same cycle: set wins, so the bit stays pending.
- Pulse arriving while its bit is already pending: coalesced, and event_overrun pulses once.
- event_ch, event_type and event_valid are stable while valid && !ready, unless a higher-priority bit becomes set (allowed; the consumer samples only on the handshake).

Test Plan:
- Reset: rst=1 for 3 cycles with btn_in=4'hF, then rst=0 -> all outputs 0 during reset. btn_level=4'hF exactly SYNC_STAGES+STABLE_CYCLES cycles after release (uses STABLE_CYCLES=4, SYNC_STAGES=2).
- Bounce: 3 ns toggles on btn_in[0] for 54 ns, then held 1 -> no intermediate btn_level change. Exactly one btn_press[0] and one event (ch=0, type=01) after the hold settles. event_ready=1.
- Priority/handshake: press ch2 and ch1 in the same cycle with event_ready=0 for 5 cycles -> event_ch=1, type=01 held stable. Raise ready for 2 cycles -> ch1 then ch2 accepted, then event_valid=0.
- Repeat: REPEAT_DELAY=8, REPEAT_RATE=4, hold ch3 for 30 cycles after acceptance -> repeat pulses at offsets 8, 12, 16, 20, 24, 28. Release -> btn_release[3] and no further repeats.
- Overrun: event_ready=0, press/release/press ch0 -> press bit coalesced, event_overrun one pulse. Drain yields press then release only.
- Mid-operation reset: assert rst while ch1 is in RATE with 2 events pending -> event_valid=0 and btn_level=0 next cycle; no repeat pulses after.

Source files
------------

// File: rtl/btn_debounce_bank.sv
// N-channel button sync/debounce with press/release/auto-repeat pulses merged into one event stream.
// Level changes SYNC_STAGES+STABLE_CYCLES edges after a clean step; events wait in per-channel pending bits until event_ready.
module btn_debounce_bank #(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_RATE   = 10000000,
  parameter int CH_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             event_valid,
  output logic [CH_W-1:0]  event_ch,
  output logic [1:0]       event_type,
  input  logic             event_ready,
  output logic             event_overrun
);

  localparam int SW   = $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);
  localparam logic [SW-1:0] S_TERM = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] D_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_TERM = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RATE  = 2'd2;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] s;
  logic [SW-1:0]    db_cnt [N_BTN];
  logic [N_BTN-1:0] term, rise, fall;
  logic [1:0]       rstate [N_BTN];
  logic [RW-1:0]    rcnt [N_BTN];
  logic [N_BTN-1:0] rep_hit;
  logic [N_BTN-1:0] pend_press, pend_release, pend_repeat;
  logic [N_BTN-1:0] sel_press, sel_release, sel_repeat;
  logic [N_BTN-1:0] clr_press, clr_release, clr_repeat;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // term: the new level has persisted long enough and flips on this edge
  always_comb begin
    term = '0;
    for (int i = 0; i < N_BTN; i++)
      term[i] = (s[i] != btn_level[i]) && (db_cnt[i] == S_TERM);
  end

  assign rise = term & ~btn_level;
  assign fall = term & btn_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if ((s[i] == btn_level[i]) || term[i]) db_cnt[i] <= '0;
        else                                   db_cnt[i] <= db_cnt[i] + 1'b1;
      end
      btn_level   <= btn_level ^ term;
      btn_press   <= rise;
      btn_release <= fall;
    end
  end

  // A release on the same edge as a terminal count suppresses the repeat
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if ((REPEAT_EN != 0) && !fall[i]) begin
        case (rstate[i])
          ST_DELAY: rep_hit[i] = (rcnt[i] == D_TERM);
          ST_RATE:  rep_hit[i] = (rcnt[i] == R_TERM);
          default:  rep_hit[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rstate[i] <= ST_IDLE;
        rcnt[i]   <= '0;
      end
      btn_repeat <= '0;
    end else begin
      btn_repeat <= rep_hit;
      for (int i = 0; i < N_BTN; i++) begin
        if ((REPEAT_EN == 0) || fall[i]) begin
          rstate[i] <= ST_IDLE;
          rcnt[i]   <= '0;
        end else begin
          case (rstate[i])
            ST_IDLE: begin
              rcnt[i] <= '0;
              if (rise[i]) rstate[i] <= ST_DELAY;
            end
            ST_DELAY: begin
              if (rcnt[i] == D_TERM) begin
                rstate[i] <= ST_RATE;
                rcnt[i]   <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            ST_RATE: begin
              if (rcnt[i] == R_TERM) rcnt[i] <= '0;
              else                   rcnt[i] <= rcnt[i] + 1'b1;
            end
            default: begin
              rstate[i] <= ST_IDLE;
              rcnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Offer the lowest pending channel; within it press > release > repeat
  always_comb begin
    sel_press   = '0;
    sel_release = '0;
    sel_repeat  = '0;
    event_valid = 1'b0;
    event_ch    = '0;
    event_type  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!event_valid && (pend_press[i] || pend_release[i] || pend_repeat[i])) begin
        event_valid = 1'b1;
        event_ch    = CH_W'(i);
        if (pend_press[i]) begin
          sel_press[i] = 1'b1;
          event_type   = EV_PRESS;
        end else if (pend_release[i]) begin
          sel_release[i] = 1'b1;
          event_type     = EV_RELEASE;
        end else begin
          sel_repeat[i] = 1'b1;
          event_type    = EV_REPEAT;
        end
      end
    end
  end

  assign clr_press   = sel_press   & {N_BTN{event_ready}};
  assign clr_release = sel_release & {N_BTN{event_ready}};
  assign clr_repeat  = sel_repeat  & {N_BTN{event_ready}};

  // A pulse landing on a bit consumed this edge is a fresh event, not an overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_press    <= '0;
      pend_release  <= '0;
      pend_repeat   <= '0;
      event_overrun <= 1'b0;
    end else begin
      pend_press    <= (pend_press   & ~clr_press)   | btn_press;
      pend_release  <= (pend_release & ~clr_release) | btn_release;
      pend_repeat   <= (pend_repeat  & ~clr_repeat)  | btn_repeat;
      event_overrun <= |((btn_press   & pend_press   & ~clr_press)   |
                         (btn_release & pend_release & ~clr_release) |
                         (btn_repeat  & pend_repeat  & ~clr_repeat));
    end
  end

endmodule
